// File: rtl/gate_vector_sequencer.sv
// Walks every gate input combination, holds each for DWELL cycles, samples gate_out on the
// last dwell cycle and compares it with EXPECTED; reports pass, mismatch count and first failing index.
module gate_vector_sequencer #(
    parameter int                    N_IN     = 3,
    parameter int                    DWELL    = 5,
    parameter logic [2**N_IN-1:0]    EXPECTED = 8'h7F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            gate_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] first_err_idx,
    output logic            first_err_valid
);

    localparam int DW_W = (DWELL > 2) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0] DW_ONE     = DW_W'(1);
    localparam logic [N_IN-1:0] IDX_LAST   = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IDX_ONE    = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE    = (N_IN + 1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [N_IN-1:0]   vec_out_q, vec_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [N_IN:0]     err_count_q, err_count_d;
    logic [N_IN-1:0]   first_err_idx_q, first_err_idx_d;
    logic              first_err_valid_q, first_err_valid_d;

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        dwell_d           = dwell_q;
        vec_out_d         = vec_out_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        pass_d            = pass_q;
        err_count_d       = err_count_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_valid_d = first_err_valid_q;

        case (state_q)
            IDLE: begin
                vec_out_d = '0;
                busy_d    = 1'b0;
                if (start && !abort) begin
                    state_d           = RUN;
                    idx_d             = '0;
                    dwell_d           = '0;
                    busy_d            = 1'b1;
                    pass_d            = 1'b0;
                    err_count_d       = '0;
                    first_err_idx_d   = '0;
                    first_err_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    // Partial error results stay visible for post-mortem.
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    vec_out_d = '0;
                    pass_d    = 1'b0;
                    idx_d     = '0;
                    dwell_d   = '0;
                end else begin
                    dwell_d = dwell_q + DW_ONE;
                    if (dwell_q == DWELL_LAST) begin
                        if (gate_out != EXPECTED[idx_q]) begin
                            err_count_d = err_count_q + ERR_ONE;
                            if (!first_err_valid_q) begin
                                first_err_idx_d   = idx_q;
                                first_err_valid_d = 1'b1;
                            end
                        end
                        dwell_d = '0;
                        if (idx_q == IDX_LAST) begin
                            // err_count_d already folds in the final vector.
                            state_d = FINISH;
                            done_d  = 1'b1;
                            pass_d  = (err_count_d == '0);
                        end else begin
                            idx_d     = idx_q + IDX_ONE;
                            vec_out_d = idx_q + IDX_ONE;
                        end
                    end
                end
            end
            FINISH: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                vec_out_d = '0;
                idx_d     = '0;
                dwell_d   = '0;
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                vec_out_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            dwell_q           <= '0;
            vec_out_q         <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            dwell_q           <= dwell_d;
            vec_out_q         <= vec_out_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_count_q       <= err_count_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign vec_out         = vec_out_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_count_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: doc/gate_vector_sequencer.md
Name: gate_vector_sequencer

Overview:
Stimulus and checker stage placed directly upstream of the 3-input combinational gate block. It walks every input combination, drives it to the gate, samples the gate's output, and compares it with a parameterised expected truth table. It replaces hand-written delay-driven stimulus with a clocked, self-checking sequencer that reports pass/fail and error detail.

Parameters:
N_IN, 3, number of gate inputs; the vector space is 2^N_IN.
DWELL, 5, clock cycles each vector is held; must be >= 2.
EXPECTED, 8'h7F, expected gate output per vector index; bit i is the expected output for vector i. The default is the 3-input NAND. Width is 2^N_IN.

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  begin a sweep; sampled only in IDLE
abort  in  1  cancel the sweep in progress
gate_out  in  1  output D of the gate under test
vec_out  out  N_IN  drives gate inputs; bit0=A, bit1=B, bit2=C
busy  out  1  high while a sweep is active (RUN or FINISH)
done  out  1  one-cycle pulse when a sweep completes
pass  out  1  registered sweep result; valid from done onward
err_count  out  N_IN+1  number of mismatching vectors in the last sweep
first_err_idx  out  N_IN  index of the first mismatching vector
first_err_valid  out  1  first_err_idx holds a recorded mismatch

Behaviour:
- Reset is synchronous, sampled on the rising edge of clk while rst_n=0. It forces state=IDLE and sets every output to 0: vec_out, busy, done, pass, err_count, first_err_idx, first_err_valid. Internal idx and dwell counters also clear to 0. Reset asserted mid-sweep behaves the same way; no done pulse is produced.
- FSM states are IDLE, RUN and FINISH.
- IDLE:
  - vec_out=0, busy=0.
  - start=1 and abort=0: go to RUN on the next edge. On entry, idx=0, dwell=0, vec_out=0. err_count, first_err_valid, first_err_idx and pass all clear to 0.
  - start and abort both high: abort wins, so the block stays in IDLE.
- RUN:
  - busy=1 and vec_out=idx.
  - dwell increments every cycle.
  - Sample cycle is dwell==DWELL-1. On that cycle gate_out is compared with EXPECTED[idx].
  - On a mismatch, err_count increments. If first_err_valid=0, first_err_idx=idx and first_err_valid=1.
  - gate_out is ignored on every cycle other than the sample cycle, so glitches during settling never count.
  - At the end of the sample cycle: if idx==2^N_IN-1, go to FINISH. Otherwise idx increments, dwell=0, and the new vec_out appears on the next cycle.
- FINISH (one cycle):
  - done=1 and busy=1.
  - pass=(err_count==0). err_count here already includes the last vector's result.
  - vec_out holds the last vector.
  - Next state is IDLE, where vec_out returns to 0.
- abort=1 in RUN: next state is IDLE, busy=0, vec_out=0, pass=0, no done pulse. err_count and first_err_* keep their partial values.
- start while busy=1 is ignored.
- Latency: start sampled at edge t gives busy=1 and vec_out=0 from edge t+1. Vector i is driven during cycles t+1+i*DWELL .. t+i*DWELL+DWELL. done pulses in cycle t+1+2^N_IN*DWELL, which is cycle t+41 for the defaults.
- Width: err_count is N_IN+1 bits, so its maximum of 2^N_IN mismatches never wraps. Index order is binary ascending, 0 to 2^N_IN-1.
- Outputs are registered. vec_out has no combinational path from any input.

Test Plan:
1. Behavioural NAND model, defaults, start pulse at cycle t -> vec_out steps 0..7, each held 5 cycles; done at t+41; pass=1, err_count=0, first_err_valid=0.
2. Gate model stuck-at-1 -> vector 7 mismatches; err_count=1, first_err_idx=7, first_err_valid=1, pass=0.
3. Model is a 3-input AND, checked against the NAND table -> all vectors mismatch; err_count=8 (4'b1000, no wrap), first_err_idx=0, pass=0.
4. abort asserted while idx=3 -> next cycle busy=0, vec_out=0, no done pulse, pass=0, err_count unchanged. A subsequent start restarts from idx 0 with counters cleared.
5. rst_n=0 for 1 cycle at idx=5 -> after that edge all outputs are 0 and state is IDLE. start pulses issued mid-sweep in another run are ignored, and done comes exactly once at t+41.
6. gate_out forced wrong on every non-sample cycle but correct on sample cycles -> err_count=0, pass=1. With DWELL=2, the sweep timing scales so that done arrives at t+17.
